// File: rtl/gpu_warp_issue_scheduler_if.sv
// rtl/gpu_warp_issue_scheduler_if.sv - warp buffer / execution unit port bundle for the issue scheduler
interface gpu_warp_issue_scheduler_if #(
  parameter int NUM_WARPS = 4,
  parameter int WARP_ID_W = 2
);
  logic [NUM_WARPS-1:0]   warp_valid_i;
  logic [8*NUM_WARPS-1:0] warp_opcode_i;
  logic [NUM_WARPS-1:0]   warp_pop_o;
  logic                   int_ready_i;
  logic                   fp_ready_i;
  logic                   mem_ready_i;
  logic                   issue_valid_o;
  logic [1:0]             issue_unit_o;
  logic [WARP_ID_W-1:0]   issue_warp_o;
  logic [7:0]             issue_opcode_o;
  logic                   sync_release_o;
  logic                   illegal_o;
  logic [WARP_ID_W-1:0]   illegal_warp_o;
  logic [NUM_WARPS-1:0]   halted_o;
  logic                   all_halted_o;

  // Scheduler side
  modport master (
    input  warp_valid_i, warp_opcode_i, int_ready_i, fp_ready_i, mem_ready_i,
    output warp_pop_o, issue_valid_o, issue_unit_o, issue_warp_o, issue_opcode_o,
    output sync_release_o, illegal_o, illegal_warp_o, halted_o, all_halted_o
  );

  // Environment side (warp buffers and execution units)
  modport slave (
    output warp_valid_i, warp_opcode_i, int_ready_i, fp_ready_i, mem_ready_i,
    input  warp_pop_o, issue_valid_o, issue_unit_o, issue_warp_o, issue_opcode_o,
    input  sync_release_o, illegal_o, illegal_warp_o, halted_o, all_halted_o
  );
endinterface

// File: rtl/gpu_warp_issue_scheduler.sv
// rtl/gpu_warp_issue_scheduler.sv - round-robin warp issue scheduler with opcode routing, barriers and FP hold-off
module gpu_warp_issue_scheduler #(
  parameter int NUM_WARPS   = 4,
  parameter int WARP_ID_W   = 2,
  parameter int FP_LONG_LAT = 8
) (
  input logic clk,
  input logic rst,
  gpu_warp_issue_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    CL_INT, CL_FP, CL_FPL, CL_MEM, CL_CTRL, CL_NOP, CL_SYNC, CL_HALT, CL_ILL
  } op_class_e;

  localparam logic [1:0] U_INT  = 2'd0;
  localparam logic [1:0] U_FP   = 2'd1;
  localparam logic [1:0] U_MEM  = 2'd2;
  localparam logic [1:0] U_CTRL = 2'd3;

  function automatic op_class_e classify(input logic [7:0] op);
    op_class_e c;
    c = CL_ILL;
    if (op inside {[8'h01:8'h06], [8'h10:8'h12], [8'h20:8'h24], [8'h30:8'h34], [8'h40:8'h49],
                   [8'h60:8'h63], [8'h70:8'h74], [8'h80:8'h81], [8'h90:8'h92]})
      c = CL_INT;
    else if (op inside {8'hA3, 8'hA6, 8'hA7, 8'hA8})
      c = CL_FPL;
    else if (op inside {[8'hA0:8'hAD], [8'hB0:8'hB5]})
      c = CL_FP;
    else if (op inside {[8'hC0:8'hC1]})
      c = CL_MEM;
    else if (op inside {[8'hE0:8'hE4], [8'hF1:8'hF2]})
      c = CL_CTRL;
    else if (op == 8'h9F)
      c = CL_NOP;
    else if (op == 8'hE5)
      c = CL_SYNC;
    else if (op == 8'hF0)
      c = CL_HALT;
    return c;
  endfunction

  // Pointer arithmetic modulo NUM_WARPS, valid for non-power-of-two warp counts.
  function automatic logic [WARP_ID_W-1:0] wrap_inc(input logic [WARP_ID_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= NUM_WARPS) s = s - NUM_WARPS;
    return WARP_ID_W'(s);
  endfunction

  logic                 issue_valid_q, issue_valid_d;
  logic [1:0]           issue_unit_q, issue_unit_d;
  logic [WARP_ID_W-1:0] issue_warp_q, issue_warp_d;
  logic [7:0]           issue_opcode_q, issue_opcode_d;
  logic                 sync_release_q, sync_release_d;
  logic                 illegal_q, illegal_d;
  logic [WARP_ID_W-1:0] illegal_warp_q, illegal_warp_d;
  logic [NUM_WARPS-1:0] halted_q, halted_d;
  logic [NUM_WARPS-1:0] parked_q, parked_d;
  logic [7:0]           fp_busy_q, fp_busy_d;
  logic [WARP_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  op_class_e            cls [NUM_WARPS];
  logic [NUM_WARPS-1:0] class_ok;
  logic [NUM_WARPS-1:0] elig;
  logic                 grant_found;
  logic [WARP_ID_W-1:0] grant_idx;
  op_class_e            grant_cls;
  logic [7:0]           grant_op;
  logic [NUM_WARPS-1:0] pop;

  // Classify every head opcode and decide which warps could be granted this cycle.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      cls[w] = classify(bus.warp_opcode_i[8*w +: 8]);
      unique case (cls[w])
        CL_INT:        class_ok[w] = bus.int_ready_i;
        CL_MEM:        class_ok[w] = bus.mem_ready_i;
        CL_FP, CL_FPL: class_ok[w] = bus.fp_ready_i & (fp_busy_q == 8'd0);
        default:       class_ok[w] = 1'b1;
      endcase
      elig[w] = ~rst & bus.warp_valid_i[w] & ~halted_q[w] & ~parked_q[w] & class_ok[w];
    end
  end

  // Round-robin pick of the first eligible warp starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!grant_found && elig[wrap_inc(rr_ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_inc(rr_ptr_q, i);
      end
    end
    grant_cls = cls[grant_idx];
    grant_op  = bus.warp_opcode_i[8*int'(grant_idx) +: 8];
    pop       = '0;
    if (grant_found) pop[grant_idx] = 1'b1;
  end

  // Next-state: barrier release on registered masks, then effects of this cycle's grant.
  always_comb begin
    issue_valid_d  = 1'b0;
    issue_unit_d   = issue_unit_q;
    issue_warp_d   = issue_warp_q;
    issue_opcode_d = issue_opcode_q;
    sync_release_d = 1'b0;
    illegal_d      = 1'b0;
    illegal_warp_d = illegal_warp_q;
    halted_d       = halted_q;
    parked_d       = parked_q;
    rr_ptr_d       = rr_ptr_q;
    fp_busy_d      = (fp_busy_q != 8'd0) ? fp_busy_q - 8'd1 : 8'd0;

    // Every warp is parked or halted, so no SYNC grant can coincide with this.
    if ((parked_q != '0) && ((parked_q | halted_q) == '1)) begin
      parked_d       = '0;
      sync_release_d = 1'b1;
    end

    if (grant_found) begin
      rr_ptr_d = wrap_inc(grant_idx, 1);
      unique case (grant_cls)
        CL_INT, CL_FP, CL_FPL, CL_MEM, CL_CTRL: begin
          issue_valid_d  = 1'b1;
          issue_warp_d   = grant_idx;
          issue_opcode_d = grant_op;
          unique case (grant_cls)
            CL_INT:        issue_unit_d = U_INT;
            CL_FP, CL_FPL: issue_unit_d = U_FP;
            CL_MEM:        issue_unit_d = U_MEM;
            default:       issue_unit_d = U_CTRL;
          endcase
          if (grant_cls == CL_FPL) fp_busy_d = 8'(FP_LONG_LAT);
        end
        CL_HALT: halted_d[grant_idx] = 1'b1;
        CL_SYNC: parked_d[grant_idx] = 1'b1;
        CL_ILL: begin
          illegal_d      = 1'b1;
          illegal_warp_d = grant_idx;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q  <= 1'b0;
      issue_unit_q   <= '0;
      issue_warp_q   <= '0;
      issue_opcode_q <= '0;
      sync_release_q <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_warp_q <= '0;
      halted_q       <= '0;
      parked_q       <= '0;
      fp_busy_q      <= '0;
      rr_ptr_q       <= '0;
    end else begin
      issue_valid_q  <= issue_valid_d;
      issue_unit_q   <= issue_unit_d;
      issue_warp_q   <= issue_warp_d;
      issue_opcode_q <= issue_opcode_d;
      sync_release_q <= sync_release_d;
      illegal_q      <= illegal_d;
      illegal_warp_q <= illegal_warp_d;
      halted_q       <= halted_d;
      parked_q       <= parked_d;
      fp_busy_q      <= fp_busy_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign bus.warp_pop_o     = pop;
  assign bus.issue_valid_o  = issue_valid_q;
  assign bus.issue_unit_o   = issue_unit_q;
  assign bus.issue_warp_o   = issue_warp_q;
  assign bus.issue_opcode_o = issue_opcode_q;
  assign bus.sync_release_o = sync_release_q;
  assign bus.illegal_o      = illegal_q;
  assign bus.illegal_warp_o = illegal_warp_q;
  assign bus.halted_o       = halted_q;
  assign bus.all_halted_o   = &halted_q;

endmodule

// File: tb/tb_gpu_warp_issue_scheduler.sv
// tb/tb_gpu_warp_issue_scheduler.sv - vector table, corner sequences and random run against a reference model
module tb_gpu_warp_issue_scheduler;
  localparam int NW  = 4;
  localparam int LAT = 8;
  localparam int C_INT = 0, C_FP = 1, C_FPL = 2, C_MEM = 3, C_CTRL = 4;
  localparam int C_NOP = 5, C_SYNC = 6, C_HALT = 7, C_ILL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpu_warp_issue_scheduler_if #(.NUM_WARPS(NW), .WARP_ID_W(2)) bus ();
  gpu_warp_issue_scheduler #(.NUM_WARPS(NW), .WARP_ID_W(2), .FP_LONG_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cls_tab [256];

  // Reference model state
  bit         m_halted [NW];
  bit         m_parked [NW];
  int         m_busy;
  int         m_rr;
  logic       e_iv, e_sync, e_ill;
  logic [1:0] e_unit, e_warp, e_illw;
  logic [7:0] e_op;
  logic [3:0] last_pop;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] ops;
    logic [2:0]  rdy;   // {int, fp, mem}
    logic [3:0]  pop;
    logic        iv;
    logic [1:0]  unit;
    logic [1:0]  warp;
    logic        ill;
  } vec_t;
  vec_t tab [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_range(input int lo, input int hi, input int c);
    for (int b = lo; b <= hi; b++) cls_tab[b] = c;
  endtask

  function automatic bit eligible(input int w);
    int c;
    c = cls_tab[bus.warp_opcode_i[8*w +: 8]];
    if (!bus.warp_valid_i[w] || m_halted[w] || m_parked[w]) return 1'b0;
    if (c == C_INT) return bus.int_ready_i;
    if (c == C_MEM) return bus.mem_ready_i;
    if (c == C_FP || c == C_FPL) return bus.fp_ready_i && (m_busy == 0);
    return 1'b1;
  endfunction

  // One scheduling decision of the reference model, from the current inputs.
  task automatic model_step(output logic [3:0] exp_pop);
    int g, c, nb;
    bit anyp, full;
    logic [7:0] op;
    exp_pop = '0;
    if (rst) begin
      for (int w = 0; w < NW; w++) begin
        m_halted[w] = 0;
        m_parked[w] = 0;
      end
      m_busy = 0; m_rr = 0;
      e_iv = 0; e_unit = 0; e_warp = 0; e_op = 0; e_sync = 0; e_ill = 0; e_illw = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < NW; k++) begin
      if (g < 0 && eligible((m_rr + k) % NW)) g = (m_rr + k) % NW;
    end
    anyp = 0; full = 1;
    for (int w = 0; w < NW; w++) begin
      anyp = anyp | m_parked[w];
      full = full & (m_parked[w] | m_halted[w]);
    end
    e_iv = 0; e_ill = 0; e_sync = anyp && full;
    if (e_sync) for (int w = 0; w < NW; w++) m_parked[w] = 0;
    nb = (m_busy > 0) ? m_busy - 1 : 0;
    if (g >= 0) begin
      exp_pop[g] = 1'b1;
      m_rr = (g + 1) % NW;
      op = bus.warp_opcode_i[8*g +: 8];
      c = cls_tab[op];
      if (c <= C_CTRL) begin
        e_iv = 1; e_warp = 2'(g); e_op = op;
        e_unit = (c == C_INT) ? 2'd0 : (c == C_MEM) ? 2'd2 : (c == C_CTRL) ? 2'd3 : 2'd1;
      end
      if (c == C_FPL) nb = LAT;
      if (c == C_HALT) m_halted[g] = 1;
      if (c == C_SYNC) m_parked[g] = 1;
      if (c == C_ILL) begin e_ill = 1; e_illw = 2'(g); end
    end
    m_busy = nb;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic do_cycle();
    logic [3:0] ep, eh;
    #1;
    model_step(ep);
    last_pop = bus.warp_pop_o;
    chk("warp_pop", 32'(bus.warp_pop_o), 32'(ep));
    @(posedge clk);
    #1;
    cyc++;
    for (int w = 0; w < NW; w++) eh[w] = m_halted[w];
    chk("issue_valid", 32'(bus.issue_valid_o), 32'(e_iv));
    chk("issue_unit", 32'(bus.issue_unit_o), 32'(e_unit));
    chk("issue_warp", 32'(bus.issue_warp_o), 32'(e_warp));
    chk("issue_opcode", 32'(bus.issue_opcode_o), 32'(e_op));
    chk("sync_release", 32'(bus.sync_release_o), 32'(e_sync));
    chk("illegal", 32'(bus.illegal_o), 32'(e_ill));
    if (e_ill) chk("illegal_warp", 32'(bus.illegal_warp_o), 32'(e_illw));
    chk("halted", 32'(bus.halted_o), 32'(eh));
    chk("all_halted", 32'(bus.all_halted_o), 32'(&eh));
    for (int w = 0; w < NW; w++) if (last_pop[w]) bus.warp_valid_i[w] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.warp_valid_i = '0;
    do_cycle();
    do_cycle();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_op(input int c);
    logic [7:0] b;
    b = 8'h01;
    for (int t = 0; t < 2000; t++) begin
      b = 8'($urandom_range(0, 255));
      if (cls_tab[b] == c) break;
    end
    return b;
  endfunction

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return pick_op(C_INT);
    if (r < 42) return pick_op(C_FP);
    if (r < 50) return pick_op(C_FPL);
    if (r < 62) return pick_op(C_MEM);
    if (r < 72) return pick_op(C_CTRL);
    if (r < 80) return 8'h9F;
    if (r < 86) return 8'hE5;
    if (r < 89) return 8'hF0;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int t0, t1, hc, rc, gc, rel_cnt;
    bit saw_int;

    for (int b = 0; b < 256; b++) cls_tab[b] = C_ILL;
    set_range(8'h01, 8'h06, C_INT); set_range(8'h10, 8'h12, C_INT); set_range(8'h20, 8'h24, C_INT);
    set_range(8'h30, 8'h34, C_INT); set_range(8'h40, 8'h49, C_INT); set_range(8'h60, 8'h63, C_INT);
    set_range(8'h70, 8'h74, C_INT); set_range(8'h80, 8'h81, C_INT); set_range(8'h90, 8'h92, C_INT);
    set_range(8'hA0, 8'hAD, C_FP);  set_range(8'hB0, 8'hB5, C_FP);
    cls_tab[8'hA3] = C_FPL; cls_tab[8'hA6] = C_FPL; cls_tab[8'hA7] = C_FPL; cls_tab[8'hA8] = C_FPL;
    set_range(8'hC0, 8'hC1, C_MEM);
    set_range(8'hE0, 8'hE4, C_CTRL); set_range(8'hF1, 8'hF2, C_CTRL);
    cls_tab[8'h9F] = C_NOP; cls_tab[8'hE5] = C_SYNC; cls_tab[8'hF0] = C_HALT;

    tab[0]  = '{4'hF, 32'h01010101, 3'b111, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b0};
    tab[1]  = '{4'hF, 32'h01010101, 3'b111, 4'b0010, 1'b1, 2'd0, 2'd1, 1'b0};
    tab[2]  = '{4'hF, 32'h01010101, 3'b111, 4'b0100, 1'b1, 2'd0, 2'd2, 1'b0};
    tab[3]  = '{4'hF, 32'h01010101, 3'b111, 4'b1000, 1'b1, 2'd0, 2'd3, 1'b0};
    tab[4]  = '{4'hF, 32'h01010101, 3'b111, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b0};
    tab[5]  = '{4'h2, 32'h00000700, 3'b111, 4'b0010, 1'b0, 2'd0, 2'd0, 1'b1};
    tab[6]  = '{4'h0, 32'h00000000, 3'b111, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0};
    tab[7]  = '{4'h3, 32'h000020C0, 3'b110, 4'b0010, 1'b1, 2'd0, 2'd1, 1'b0};
    tab[8]  = '{4'h1, 32'h000020C0, 3'b111, 4'b0001, 1'b1, 2'd2, 2'd0, 1'b0};
    tab[9]  = '{4'h4, 32'h00E00000, 3'b111, 4'b0100, 1'b1, 2'd3, 2'd2, 1'b0};
    tab[10] = '{4'h8, 32'hA0000000, 3'b101, 4'b0000, 1'b0, 2'd3, 2'd2, 1'b0};
    tab[11] = '{4'h8, 32'hA0000000, 3'b111, 4'b1000, 1'b1, 2'd1, 2'd3, 1'b0};

    bus.warp_valid_i = '0; bus.warp_opcode_i = '0;
    bus.int_ready_i = 1'b1; bus.fp_ready_i = 1'b1; bus.mem_ready_i = 1'b1;
    @(negedge clk);
    do_reset();

    // Vector table: round-robin INT, illegal drop, MEM stall, CTRL, FP ready gating
    for (int i = 0; i < 12; i++) begin
      bus.warp_valid_i  = tab[i].valid;
      bus.warp_opcode_i = tab[i].ops;
      {bus.int_ready_i, bus.fp_ready_i, bus.mem_ready_i} = tab[i].rdy;
      do_cycle();
      chk("tab_pop", 32'(last_pop), 32'(tab[i].pop));
      chk("tab_issue_valid", 32'(bus.issue_valid_o), 32'(tab[i].iv));
      chk("tab_issue_unit", 32'(bus.issue_unit_o), 32'(tab[i].unit));
      chk("tab_issue_warp", 32'(bus.issue_warp_o), 32'(tab[i].warp));
      chk("tab_illegal", 32'(bus.illegal_o), 32'(tab[i].ill));
      if (tab[i].ill) chk("tab_illegal_warp", 32'(bus.illegal_warp_o), 32'd1);
    end
    chk("illegal_not_halted", 32'(bus.halted_o), 32'd0);

    // Long FP hold-off: FADD follows FDIV by 1 + LAT cycles, INT slips in between
    do_reset();
    bus.int_ready_i = 1'b1; bus.fp_ready_i = 1'b1; bus.mem_ready_i = 1'b1;
    bus.warp_opcode_i = {8'h00, 8'h00, 8'hA0, 8'hA3};
    bus.warp_valid_i  = 4'b0011;
    t0 = -1; t1 = -1; saw_int = 0;
    for (int k = 0; k < 30 && t1 < 0; k++) begin
      if (k == 2) begin
        bus.warp_opcode_i[23:16] = 8'h01;
        bus.warp_valid_i[2] = 1'b1;
      end
      do_cycle();
      if (bus.issue_valid_o) begin
        if (bus.issue_warp_o == 2'd0 && t0 < 0) t0 = cyc;
        else if (bus.issue_warp_o == 2'd1 && bus.issue_unit_o == 2'd1) t1 = cyc;
        else if (bus.issue_warp_o == 2'd2 && bus.issue_unit_o == 2'd0 && t0 >= 0) saw_int = 1;
      end
    end
    chk("fp_long_gap", 32'(t1 - t0), 32'd9);
    chk("int_during_fp_busy", 32'(saw_int), 32'd1);

    // Barrier: W0..W2 SYNC, W3 HALT, release, W0 regranted
    do_reset();
    bus.warp_opcode_i = {8'h00, 8'hE5, 8'hE5, 8'hE5};
    bus.warp_valid_i  = 4'b0111;
    for (int k = 0; k < 3; k++) do_cycle();
    bus.warp_opcode_i = {8'hF0, 8'h00, 8'h00, 8'h01};
    bus.warp_valid_i  = 4'b1001;
    hc = -1; rc = -1; gc = -1; rel_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      do_cycle();
      if (hc < 0 && bus.halted_o == 4'b1000) hc = cyc;
      if (bus.sync_release_o) begin
        rel_cnt++;
        if (rc < 0) rc = cyc;
      end
      if (gc < 0 && bus.issue_valid_o && bus.issue_warp_o == 2'd0) gc = cyc;
    end
    chk("barrier_halted_mask", 32'(bus.halted_o), 32'h8);
    chk("barrier_release_delay", 32'(rc - hc), 32'd1);
    chk("barrier_release_pulses", 32'(rel_cnt), 32'd1);
    chk("barrier_regrant_w0", 32'(gc - rc), 32'd1);

    // Reset while parked and FP busy
    do_reset();
    bus.warp_opcode_i = {8'h00, 8'h00, 8'hE5, 8'hA3};
    bus.warp_valid_i  = 4'b0011;
    for (int k = 0; k < 4; k++) do_cycle();
    bus.warp_opcode_i = {8'h01, 8'h01, 8'h01, 8'h01};
    bus.warp_valid_i  = 4'b1100;
    rst = 1'b1;
    do_cycle();
    chk("rst_pop", 32'(last_pop), 32'd0);
    chk("rst_outputs", {bus.issue_valid_o, bus.issue_unit_o, bus.issue_warp_o, bus.issue_opcode_o,
                        bus.sync_release_o, bus.illegal_o, bus.illegal_warp_o, bus.halted_o,
                        bus.all_halted_o}, 32'd0);
    rst = 1'b0;
    bus.warp_opcode_i = {8'h01, 8'h01, 8'h01, 8'hA0};
    bus.warp_valid_i  = 4'b1111;
    do_cycle();
    chk("rst_first_grant", 32'(last_pop), 32'd1);
    chk("rst_fp_unblocked", 32'({bus.issue_valid_o, bus.issue_unit_o}), 32'b101);
    do_cycle();
    chk("rst_unparked_w1", 32'(last_pop), 32'd2);

    // Randomized run against the model; stalled heads keep their opcode
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = (n % 250 == 0) || ($urandom_range(0, 299) == 0);
      for (int w = 0; w < NW; w++) begin
        if (!bus.warp_valid_i[w] && $urandom_range(0, 3) != 0) begin
          bus.warp_valid_i[w] = 1'b1;
          bus.warp_opcode_i[8*w +: 8] = rand_op();
        end
      end
      bus.int_ready_i = ($urandom_range(0, 3) != 0);
      bus.fp_ready_i  = ($urandom_range(0, 3) != 0);
      bus.mem_ready_i = ($urandom_range(0, 3) != 0);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
